// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    localparam logic [31:0] NOP_DEFAULT = 32'h20000000;

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Word-addressed cache: two byte-offset bits sit below the index.
    function automatic int tag_w(input int addr_w, input int lines);
        return addr_w - $clog2(lines) - 2;
    endfunction

endpackage

// File: rtl/icache_store.sv
// Line array for icache_dm: data/tag storage plus resettable valid vector.
module icache_store
    import icache_pkg::*;
#(
    parameter int LINES = 8,
    parameter int IDX_W = 3,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i,
    input  logic             wr_valid_i,
    input  logic             flush_i,
    output logic [31:0]      rd_data_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic             rd_valid_o
);

    logic [31:0]      data_q [LINES];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;

    always_ff @(posedge clk) begin
        if (we_i) begin
            data_q[wr_idx_i] <= wr_data_i;
            tag_q[wr_idx_i]  <= wr_tag_i;
        end
    end

    // A write on the flush edge lands after the clear, carrying its own valid.
    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end
        if (we_i) begin
            valid_d[wr_idx_i] = wr_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign rd_data_o  = data_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with refill handshake and flush.
// Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache_dm
    import icache_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int          LINES     = 8,
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(ADDR_W, LINES);

    if (ADDR_W < IDX_W + 3) begin : g_bad_addr_w
        $error("icache_dm: ADDR_W too small for LINES");
    end
    if (LINES < 2 || (1 << IDX_W) != LINES) begin : g_bad_lines
        $error("icache_dm: LINES must be a power of two >= 2");
    end

    state_e            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              stall_q, stall_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [TAG_W-1:0]  req_tag_q, req_tag_d;
    logic [IDX_W-1:0]  req_idx_q, req_idx_d;
    logic              flushed_q, flushed_d;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [31:0]       rd_data;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    logic              lookup;
    logic              hit;
    logic              we;
    logic              wr_valid;
    logic              unused_addr_bits;

    assign req_idx          = req_addr[IDX_W+1:2];
    assign req_tag          = req_addr[ADDR_W-1:IDX_W+2];
    assign unused_addr_bits = ^req_addr[1:0];

    icache_store #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_store (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (req_idx),
        .we_i       (we),
        .wr_idx_i   (req_idx_q),
        .wr_tag_i   (req_tag_q),
        .wr_data_i  (mem_data),
        .wr_valid_i (wr_valid),
        .flush_i    (flush),
        .rd_data_o  (rd_data),
        .rd_tag_o   (rd_tag),
        .rd_valid_o (rd_valid)
    );

    assign lookup = (state_q == IDLE) && req_valid;
    assign hit    = lookup && rd_valid && (rd_tag == req_tag);

    always_comb begin
        state_d       = state_q;
        instr_d       = NOP_INSTR;
        instr_valid_d = 1'b0;
        stall_d       = stall_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        req_tag_d     = req_tag_q;
        req_idx_d     = req_idx_q;
        flushed_d     = flushed_q;
        we            = 1'b0;
        wr_valid      = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall_d   = 1'b0;
                mem_req_d = 1'b0;
                flushed_d = 1'b0;
                if (hit) begin
                    instr_d       = rd_data;
                    instr_valid_d = 1'b1;
                end else if (lookup) begin
                    state_d    = FILL;
                    stall_d    = 1'b1;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                    req_tag_d  = req_tag;
                    req_idx_d  = req_idx;
                end
            end
            FILL: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                // A flush seen at any point of the refill leaves the line invalid.
                if (mem_ack) begin
                    we            = 1'b1;
                    wr_valid      = !(flushed_q || flush);
                    instr_d       = mem_data;
                    instr_valid_d = 1'b1;
                    stall_d       = 1'b0;
                    mem_req_d     = 1'b0;
                    flushed_d     = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            stall_q       <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            req_tag_q     <= '0;
            req_idx_q     <= '0;
            flushed_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            stall_q       <= stall_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            req_tag_q     <= req_tag_d;
            req_idx_q     <= req_idx_d;
            flushed_q     <= flushed_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign stall       = stall_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit && hit_cnt_q != 32'hFFFFFFFF) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (lookup && !hit && miss_cnt_q != 32'hFFFFFFFF) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: refill, hit, conflict, flush and reset cases.
module tb_icache_dm;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [7:0]  req_addr = '0;
    logic        flush = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    localparam logic [31:0] NOP = 32'h20000000;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    icache_dm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    // fmode: 0 none, 1 flush with request, 2 flush at ack, 3 flush mid-refill
    task automatic fetch(
        input  logic [7:0]  a,
        input  int          waits,
        input  logic [31:0] d,
        input  int          fmode,
        output logic        miss,
        output logic [31:0] first_i,
        output logic        first_v,
        output logic        first_req,
        output logic [7:0]  maddr,
        output int          stalls,
        output logic        end_stall,
        output logic [31:0] res_i,
        output logic        res_v
    );
        req_valid = 1'b1;
        req_addr  = a;
        flush     = (fmode == 1);
        @(posedge clk); #1;
        flush     = 1'b0;
        first_i   = instr;
        first_v   = instr_valid;
        first_req = mem_req;
        maddr     = mem_addr;
        miss      = stall;
        stalls    = 0;
        res_i     = instr;
        res_v     = instr_valid;
        end_stall = stall;
        if (miss) begin
            for (int w = 0; w < waits; w++) begin
                if (stall) stalls++;
                flush = (fmode == 3 && w == 0);
                @(posedge clk); #1;
                flush = 1'b0;
            end
            if (stall) stalls++;
            mem_ack  = 1'b1;
            mem_data = d;
            flush    = (fmode == 2);
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            flush     = 1'b0;
            res_i     = instr;
            res_v     = instr_valid;
            end_stall = stall;
        end
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (instr !== NOP) begin
            n_err++; $display("FAIL reset_instr got %h want %h", instr, NOP);
        end
        n_vec++;
        if (instr_valid !== 1'b0 || stall !== 1'b0) begin
            n_err++; $display("FAIL reset_flags got v=%b s=%b want 0 0", instr_valid, stall);
        end
        n_vec++;
        if (mem_req !== 1'b0 || mem_addr !== 8'h00) begin
            n_err++; $display("FAIL reset_mem got req=%b addr=%h want 0 00", mem_req, mem_addr);
        end
    endtask

    task automatic test_miss_fill();
        logic m, fv, fr, es, rv; logic [31:0] fi, ri; logic [7:0] ma; int st;
        exp_t e;
        exp_q.push_back('{instr: 32'hDEADBEEF, valid: 1'b1});
        fetch(8'h04, 3, 32'hDEADBEEF, 0, m, fi, fv, fr, ma, st, es, ri, rv);
        n_vec++;
        if (m !== 1'b1 || fr !== 1'b1 || ma !== 8'h04) begin
            n_err++; $display("FAIL miss_req got miss=%b req=%b addr=%h want 1 1 04", m, fr, ma);
        end
        n_vec++;
        if (fi !== NOP || fv !== 1'b0) begin
            n_err++; $display("FAIL miss_bubble got %h v=%b want %h v=0", fi, fv, NOP);
        end
        n_vec++;
        if (st != 4 || es !== 1'b0) begin
            n_err++; $display("FAIL miss_stall got cycles=%0d end=%b want 4 0", st, es);
        end
        e = exp_q.pop_front();
        n_vec++;
        if (ri !== e.instr || rv !== e.valid) begin
            n_err++; $display("FAIL miss_data got %h v=%b want %h v=%b", ri, rv, e.instr, e.valid);
        end
    endtask

    task automatic test_hit();
        logic m, fv, fr, es, rv; logic [31:0] fi, ri; logic [7:0] ma; int st;
        exp_t e;
        exp_q.push_back('{instr: 32'hDEADBEEF, valid: 1'b1});
        fetch(8'h04, 0, 32'h0, 0, m, fi, fv, fr, ma, st, es, ri, rv);
        e = exp_q.pop_front();
        n_vec++;
        if (m !== 1'b0 || fr !== 1'b0) begin
            n_err++; $display("FAIL hit_nomem got stall=%b req=%b want 0 0", m, fr);
        end
        n_vec++;
        if (ri !== e.instr || rv !== e.valid) begin
            n_err++; $display("FAIL hit_data got %h v=%b want %h v=%b", ri, rv, e.instr, e.valid);
        end
        exp_q.push_back('{instr: 32'hCAFEF00D, valid: 1'b1});
        fetch(8'h08, 0, 32'hCAFEF00D, 0, m, fi, fv, fr, ma, st, es, ri, rv);
        e = exp_q.pop_front();
        n_vec++;
        if (ri !== e.instr || rv !== e.valid || ma !== 8'h08) begin
            n_err++; $display("FAIL fill08 got %h v=%b addr=%h want %h v=1 addr=08", ri, rv, ma, e.instr);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] o_i [2];
        logic        o_v [2];
        exp_q.push_back('{instr: 32'hDEADBEEF, valid: 1'b1});
        exp_q.push_back('{instr: 32'hCAFEF00D, valid: 1'b1});
        req_valid = 1'b1;
        req_addr  = 8'h04;
        @(posedge clk); #1;
        o_i[0] = instr; o_v[0] = instr_valid;
        req_addr = 8'h08;
        @(posedge clk); #1;
        o_i[1] = instr; o_v[1] = instr_valid;
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (o_i[k] !== e.instr || o_v[k] !== e.valid) begin
                n_err++; $display("FAIL b2b_%0d got %h v=%b want %h v=%b", k, o_i[k], o_v[k], e.instr, e.valid);
            end
        end
    endtask

    task automatic test_conflict();
        logic m, fv, fr, es, rv; logic [31:0] fi, ri; logic [7:0] ma; int st;
        exp_t e;
        logic [7:0]  addrs [4] = '{8'h04, 8'h24, 8'h04, 8'h04};
        logic [31:0] words [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h0};
        logic        misses[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{instr: (k == 3) ? 32'h33333333 : words[k], valid: 1'b1});
            fetch(addrs[k], k, words[k], 0, m, fi, fv, fr, ma, st, es, ri, rv);
            e = exp_q.pop_front();
            n_vec++;
            if (m !== misses[k] || (m && ma !== addrs[k])) begin
                n_err++; $display("FAIL conflict_miss_%0d got miss=%b addr=%h want %b %h", k, m, ma, misses[k], addrs[k]);
            end
            n_vec++;
            if (ri !== e.instr || rv !== e.valid) begin
                n_err++; $display("FAIL conflict_data_%0d got %h v=%b want %h v=%b", k, ri, rv, e.instr, e.valid);
            end
        end
    endtask

    task automatic test_flush();
        logic m, fv, fr, es, rv; logic [31:0] fi, ri; logic [7:0] ma; int st;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        fetch(8'h04, 1, 32'h44444444, 0, m, fi, fv, fr, ma, st, es, ri, rv);
        n_vec++;
        if (m !== 1'b1 || fi !== NOP || fv !== 1'b0 || fr !== 1'b1) begin
            n_err++; $display("FAIL flush_idle got miss=%b %h v=%b req=%b want 1 %h 0 1", m, fi, fv, fr, NOP);
        end
        fetch(8'h10, 2, 32'h10101010, 3, m, fi, fv, fr, ma, st, es, ri, rv);
        n_vec++;
        if (ri !== 32'h10101010 || rv !== 1'b1) begin
            n_err++; $display("FAIL flush_fill_data got %h v=%b want 10101010 v=1", ri, rv);
        end
        fetch(8'h10, 0, 32'h10101011, 0, m, fi, fv, fr, ma, st, es, ri, rv);
        n_vec++;
        if (m !== 1'b1) begin
            n_err++; $display("FAIL flush_fill_inval got miss=%b want 1", m);
        end
        fetch(8'h14, 1, 32'h14141414, 2, m, fi, fv, fr, ma, st, es, ri, rv);
        fetch(8'h14, 0, 32'h14141415, 0, m, fi, fv, fr, ma, st, es, ri, rv);
        n_vec++;
        if (m !== 1'b1) begin
            n_err++; $display("FAIL flush_ack_inval got miss=%b want 1", m);
        end
        fetch(8'h14, 0, 32'h0, 1, m, fi, fv, fr, ma, st, es, ri, rv);
        n_vec++;
        if (m !== 1'b0 || ri !== 32'h14141415 || rv !== 1'b1) begin
            n_err++; $display("FAIL flush_same_hit got miss=%b %h v=%b want 0 14141415 1", m, ri, rv);
        end
        fetch(8'h14, 0, 32'h14141416, 0, m, fi, fv, fr, ma, st, es, ri, rv);
        n_vec++;
        if (m !== 1'b1) begin
            n_err++; $display("FAIL flush_after_hit got miss=%b want 1", m);
        end
    endtask

    task automatic test_reset_fill();
        logic m, fv, fr, es, rv; logic [31:0] fi, ri; logic [7:0] ma; int st;
        req_valid = 1'b1;
        req_addr  = 8'h18;
        @(posedge clk); #1;
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h18) begin
            n_err++; $display("FAIL rstfill_req got req=%b addr=%h want 1 18", mem_req, mem_addr);
        end
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        mem_ack  = 1'b1;
        mem_data = 32'h18181818;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        n_vec++;
        if (mem_req !== 1'b0 || instr !== NOP || instr_valid !== 1'b0 || stall !== 1'b0) begin
            n_err++; $display("FAIL rstfill_ack got req=%b %h v=%b s=%b want 0 %h 0 0", mem_req, instr, instr_valid, stall, NOP);
        end
        fetch(8'h18, 0, 32'h18181819, 0, m, fi, fv, fr, ma, st, es, ri, rv);
        n_vec++;
        if (m !== 1'b1 || ri !== 32'h18181819) begin
            n_err++; $display("FAIL rstfill_remiss got miss=%b %h want 1 18181819", m, ri);
        end
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        logic m, fv, fr, es, rv; logic [31:0] fi, ri; logic [7:0] ma; int st;
        do_reset();
        n_vec++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            n_err++; $display("FAIL stats_reset got h=%0d m=%0d want 0 0", hit_cnt, miss_cnt);
        end
        fetch(8'h04, 1, 32'h55555555, 0, m, fi, fv, fr, ma, st, es, ri, rv);
        for (int k = 0; k < 3; k++) begin
            fetch(8'h04, 0, 32'h0, 0, m, fi, fv, fr, ma, st, es, ri, rv);
        end
        n_vec++;
        if (hit_cnt !== 32'd3 || miss_cnt !== 32'd1) begin
            n_err++; $display("FAIL stats_count got h=%0d m=%0d want 3 1", hit_cnt, miss_cnt);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_vec++;
        if (hit_cnt !== 32'd3 || miss_cnt !== 32'd1) begin
            n_err++; $display("FAIL stats_flush got h=%0d m=%0d want 3 1", hit_cnt, miss_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_miss_fill();
        test_hit();
        test_back_to_back();
        test_conflict();
        test_flush();
        test_reset_fill();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Parametrised direct-mapped instruction cache between the fetch stage and instruction memory.
- Generalises the 8-line, 8-bit-address fetch cache to configurable address width and depth.
- Adds per-line valid bits, a synchronous reset, a miss/refill handshake to the backing memory, a fetch stall, and a whole-cache flush.
- Returns a NOP bubble whenever no valid instruction is available.

Parameters:
- ADDR_W, 8, byte-address width of fetch and memory addresses.
- LINES, 8, number of one-word lines; power of two, >= 2.
- NOP_INSTR, 32'h20000000, instruction driven when instr_valid=0.

Ports:
- clk, in, 1, single clock; all state updates on posedge.
- rst_n, in, 1, synchronous active-low reset.
- req_valid, in, 1, fetch request present this cycle.
- req_addr, in, ADDR_W, byte address; bits [1:0] ignored.
- flush, in, 1, invalidate all lines.
- instr, out, 32, fetched instruction, registered.
- instr_valid, out, 1, instr is the word for the last accepted request.
- stall, out, 1, cache busy; fetch holds req_addr and does not advance.
- mem_req, out, 1, refill request; level, held until ack.
- mem_addr, out, ADDR_W, word-aligned refill address ([1:0]=0).
- mem_ack, in, 1, mem_data valid; completes refill.
- mem_data, in, 32, refill word.

Behaviour:
- Address split: IDX_W=$clog2(LINES); index=req_addr[IDX_W+1:2]; tag=req_addr[ADDR_W-1:IDX_W+2]. Elaboration error if ADDR_W < IDX_W+3.
- Storage: per line, data[31:0], tag[TAG_W-1:0] and valid. Valid bits live in flops (resettable); data/tag contents undefined after reset.
- Reset (rst_n=0 at posedge): all valid=0, state=IDLE, instr=NOP_INSTR, instr_valid=0, stall=0, mem_req=0, mem_addr=0. Reset during FILL abandons the refill: mem_req drops next cycle and a late mem_ack is ignored.
- FSM states: IDLE, FILL.
- IDLE, req_valid=1, hit (valid && tag match):
  - Next posedge: instr=line data, instr_valid=1, stall=0.
  - Latency: 1 cycle; back-to-back hits give 1 instr/cycle.
- IDLE, req_valid=1, miss:
  - Next posedge: instr=NOP_INSTR, instr_valid=0, stall=1, mem_req=1, mem_addr={req_addr[ADDR_W-1:2],2'b00}; request tag and index latched; state=FILL.
- IDLE, req_valid=0: instr=NOP_INSTR, instr_valid=0, stall=0.
- FILL:
  - stall=1, mem_req=1, mem_addr constant; req_addr/req_valid ignored.
  - On posedge with mem_ack=1: write line (data, tag, valid=1); instr=mem_data, instr_valid=1, stall=0, mem_req=0; state=IDLE.
  - Result: miss latency = 2 + memory wait cycles.
- Flush:
  - IDLE: clears every valid bit at the posedge. A lookup in the same cycle uses pre-flush valids, so a hit is still returned that cycle.
  - FILL: valids cleared immediately. The completing refill still returns mem_data with instr_valid=1, but its line is written with valid=0.
  - Flush coincident with the mem_ack posedge behaves the same way: line left invalid.
- Wrap-around: distinct tags on the same index evict; no replacement state.
- Same-index refill immediately followed by a request to that line hits (write visible the next cycle).

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Cleared by rst_n only, not by flush.
  - Incremented at the posedge a lookup resolves as hit or miss.
  - Saturate at 32'hFFFFFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package icache_pkg:
  - State enum {IDLE, FILL}.
  - Default NOP constant 32'h20000000.
  - Width helper functions for IDX_W and TAG_W.
- One sub-module, icache_store: the LINES-entry data/tag array plus valid vector.
  - Inputs: read index, write enable/index/tag/data/valid, flush.
  - Outputs: combinational data, tag and valid at the read index.
- icache_dm keeps the FSM, compare, output registers and stats.

Test Plan:
- Reset, then req_addr=8'h04 with mem_ack after 3 wait cycles, mem_data=32'hDEADBEEF -> mem_req=1, mem_addr=8'h04, stall=1 for 4 cycles; then instr=32'hDEADBEEF, instr_valid=1.
- Repeat req_addr=8'h04 -> hit, instr=32'hDEADBEEF next cycle, mem_req stays 0; requests 8'h04 then 8'h08 (both cached) -> 2 consecutive valid instrs.
- Conflict: 8'h04, then 8'h24 (same index 1, LINES=8), then 8'h04 -> three misses, each mem_addr correct, final data is 8'h04's word.
- flush=1 after filling 8'h04, then request 8'h04 -> miss, instr=32'h20000000 with instr_valid=0, mem_req=1.
- rst_n=0 during FILL, then mem_ack=1 -> mem_req=0, valid bit for that line 0, instr=NOP_INSTR; the next request to the same address misses.
- ICACHE_STATS_EN defined: 1 miss + 3 hits -> miss_cnt=1, hit_cnt=3; flush leaves both unchanged.
